// File: rtl/i2c_regmap_arbiter_if.sv
// Bus bundle between the regmap arbiter and its two requesters: the I2C slave
// regmap port and the on-chip host command port, plus the change-notification
// outputs. The arbiter connects through the slave modport.
interface i2c_regmap_arbiter_if;

    // I2C slave regmap port
    logic       i2c_active;
    logic [7:0] i2c_addr;
    logic [7:0] i2c_wdata;
    logic       i2c_wr_pulse;
    logic [7:0] i2c_rdata;

    // Host command port
    logic       host_req_valid;
    logic       host_req_we;
    logic [7:0] host_req_addr;
    logic [7:0] host_req_wdata;
    logic       host_req_ready;
    logic       host_rsp_valid;
    logic [7:0] host_rsp_rdata;
    logic       host_rsp_err;

    // Register change notification
    logic       reg_upd_pulse;
    logic [7:0] reg_upd_addr;
    logic       reg_upd_src;

    modport master (
        output i2c_active,
        output i2c_addr,
        output i2c_wdata,
        output i2c_wr_pulse,
        input  i2c_rdata,
        output host_req_valid,
        output host_req_we,
        output host_req_addr,
        output host_req_wdata,
        input  host_req_ready,
        input  host_rsp_valid,
        input  host_rsp_rdata,
        input  host_rsp_err,
        input  reg_upd_pulse,
        input  reg_upd_addr,
        input  reg_upd_src
    );

    modport slave (
        input  i2c_active,
        input  i2c_addr,
        input  i2c_wdata,
        input  i2c_wr_pulse,
        output i2c_rdata,
        input  host_req_valid,
        input  host_req_we,
        input  host_req_addr,
        input  host_req_wdata,
        output host_req_ready,
        output host_rsp_valid,
        output host_rsp_rdata,
        output host_rsp_err,
        output reg_upd_pulse,
        output reg_upd_addr,
        output reg_upd_src
    );

endinterface

// File: rtl/i2c_regmap_arbiter.sv
// 8-bit register file shared between the I2C slave (writes can never stall, so
// they always win) and a host valid/ready port served by an IDLE/EXEC/RESP FSM.
// Every committed write produces a one-cycle change notification.
// Optional feature macro: I2C_LOCK_EN -- while an I2C transaction is active the
// host port is locked out, up to LOCK_TIMEOUT cycles, after which the lock is
// released until i2c_active falls and lock_timeout latches high.
module i2c_regmap_arbiter #(
    parameter int unsigned NUM_REGS     = 256,
    parameter logic [15:0] LOCK_TIMEOUT = 16'd50000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    i2c_regmap_arbiter_if.slave         bus,
    output logic [15:0]                 conflict_cnt,
    output logic                        lock_timeout
);

    localparam int unsigned AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_e;

    state_e     state_q, state_d;

    logic [7:0] regs_q [NUM_REGS];

    // Captured host request
    logic       host_we_q;
    logic [7:0] host_addr_q;
    logic [7:0] host_wdata_q;

    // Captured host response
    logic [7:0] rsp_rdata_q;
    logic       rsp_err_q;

    // Low during reset and for the first edge after it, so ready is 0 in reset
    logic       init_q;

    logic [7:0] i2c_rdata_q;
    logic       upd_pulse_q;
    logic [7:0] upd_addr_q;
    logic       upd_src_q;
    logic [15:0] conflict_q;

    logic       lock;
    logic       host_ready;
    logic       host_accept;
    logic       host_commit;
    logic       host_conflict;

    logic          i2c_in_range;
    logic          host_in_range;
    logic [AW-1:0] i2c_idx;
    logic [AW-1:0] host_idx;
    logic          i2c_wr_en;
    logic          host_wr_en;

    assign i2c_in_range  = 32'(bus.i2c_addr) < NUM_REGS;
    assign host_in_range = 32'(host_addr_q) < NUM_REGS;
    assign i2c_idx       = bus.i2c_addr[AW-1:0];
    assign host_idx      = host_addr_q[AW-1:0];

    // Out-of-range writes are dropped silently on both ports
    assign i2c_wr_en  = bus.i2c_wr_pulse && i2c_in_range;
    assign host_wr_en = host_commit && host_we_q && host_in_range;

`ifdef I2C_LOCK_EN
    logic [15:0] lock_cnt_q;
    logic        lock_timeout_q;
    logic        lock_released;

    // Counter parks at LOCK_TIMEOUT, keeping the lock released until i2c_active falls
    assign lock_released = (lock_cnt_q == LOCK_TIMEOUT);
    assign lock          = bus.i2c_active && !lock_released;
    assign lock_timeout  = lock_timeout_q;

    // Count cycles of the current I2C transaction and latch an expiry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_cnt_q     <= 16'd0;
            lock_timeout_q <= 1'b0;
        end else begin
            if (!bus.i2c_active) begin
                lock_cnt_q <= 16'd0;
            end else if (!lock_released) begin
                lock_cnt_q <= lock_cnt_q + 16'd1;
            end
            if (bus.i2c_active && lock_released) begin
                lock_timeout_q <= 1'b1;
            end
        end
    end
`else
    logic unused_lock_inputs;

    assign lock               = 1'b0;
    assign lock_timeout       = 1'b0;
    assign unused_lock_inputs = ^{bus.i2c_active, LOCK_TIMEOUT};
`endif

    // Host FSM next state and handshake decode
    always_comb begin
        state_d       = state_q;
        host_ready    = 1'b0;
        host_accept   = 1'b0;
        host_commit   = 1'b0;
        host_conflict = 1'b0;
        unique case (state_q)
            StIdle: begin
                host_ready = init_q && !bus.i2c_wr_pulse && !lock;
                if (bus.host_req_valid && host_ready) begin
                    host_accept = 1'b1;
                    state_d     = StExec;
                end
            end
            StExec: begin
                // An I2C write owns the register file this cycle; retry next cycle
                if (bus.i2c_wr_pulse) begin
                    host_conflict = 1'b1;
                end else begin
                    host_commit = 1'b1;
                    state_d     = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM state, init flag and request capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            init_q       <= 1'b0;
            host_we_q    <= 1'b0;
            host_addr_q  <= 8'h00;
            host_wdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            init_q  <= 1'b1;
            if (host_accept) begin
                host_we_q    <= bus.host_req_we;
                host_addr_q  <= bus.host_req_addr;
                host_wdata_q <= bus.host_req_wdata;
            end
        end
    end

    // Register file: I2C write first, host commit only when no I2C write is present
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else if (i2c_wr_en) begin
            regs_q[i2c_idx] <= bus.i2c_wdata;
        end else if (host_wr_en) begin
            regs_q[host_idx] <= host_wdata_q;
        end
    end

    // I2C read data, registered every cycle from the pre-write register contents
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i2c_rdata_q <= 8'h00;
        end else begin
            i2c_rdata_q <= i2c_in_range ? regs_q[i2c_idx] : 8'hFF;
        end
    end

    // Host response capture at commit; rdata is zero for writes and errors
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_rdata_q <= 8'h00;
            rsp_err_q   <= 1'b0;
        end else if (host_commit) begin
            rsp_rdata_q <= (!host_we_q && host_in_range) ? regs_q[host_idx] : 8'h00;
            rsp_err_q   <= !host_in_range;
        end
    end

    // Change notification, one cycle after the write lands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd_pulse_q <= 1'b0;
            upd_addr_q  <= 8'h00;
            upd_src_q   <= 1'b0;
        end else begin
            upd_pulse_q <= i2c_wr_en || host_wr_en;
            upd_src_q   <= host_wr_en;
            if (i2c_wr_en) begin
                upd_addr_q <= bus.i2c_addr;
            end else if (host_wr_en) begin
                upd_addr_q <= host_addr_q;
            end else begin
                upd_addr_q <= 8'h00;
            end
        end
    end

    // Saturating count of host EXEC stalls caused by I2C writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_q <= 16'h0000;
        end else if (host_conflict && (conflict_q != 16'hFFFF)) begin
            conflict_q <= conflict_q + 16'h0001;
        end
    end

    assign bus.i2c_rdata      = i2c_rdata_q;
    assign bus.host_req_ready = host_ready;
    assign bus.host_rsp_valid = (state_q == StResp);
    assign bus.host_rsp_rdata = (state_q == StResp) ? rsp_rdata_q : 8'h00;
    assign bus.host_rsp_err   = (state_q == StResp) ? rsp_err_q : 1'b0;
    assign bus.reg_upd_pulse  = upd_pulse_q;
    assign bus.reg_upd_addr   = upd_addr_q;
    assign bus.reg_upd_src    = upd_src_q;
    assign conflict_cnt       = conflict_q;

endmodule

// File: tb/tb_i2c_regmap_arbiter.sv
// Self-checking bench for i2c_regmap_arbiter: directed scenarios plus random
// traffic, every cycle compared against a transaction-level register model.
module tb_i2c_regmap_arbiter;

    localparam int unsigned NUM_REGS     = 32;
    localparam logic [15:0] LOCK_TIMEOUT = 16'd100;

`ifdef I2C_LOCK_EN
    localparam int  EXP_FIRST_ACC = 100;
    localparam logic EXP_LOCK_TO  = 1'b1;
`else
    localparam int  EXP_FIRST_ACC = 0;
    localparam logic EXP_LOCK_TO  = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [15:0] conflict_cnt;
    logic        lock_timeout;

    i2c_regmap_arbiter_if bus ();

    i2c_regmap_arbiter #(
        .NUM_REGS     (NUM_REGS),
        .LOCK_TIMEOUT (LOCK_TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .conflict_cnt (conflict_cnt),
        .lock_timeout (lock_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks;
    int unsigned errors;

    // Reference model state
    logic [7:0]  m_regs [256];
    int          busy;        // 0 free, 1 accepted awaiting commit, 2 responding
    logic        p_we;
    logic [7:0]  p_addr;
    logic [7:0]  p_wdata;
    int unsigned m_conf;
    logic [7:0]  e_rdata;
    logic        e_upd;
    logic [7:0]  e_upd_addr;
    logic        e_upd_src;
    logic        e_rsp;
    logic [7:0]  e_rsp_rdata;
    logic        e_rsp_err;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit in_range(input logic [7:0] a);
        return 32'(a) < NUM_REGS;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 256; i++) m_regs[i] = 8'h00;
        busy        = 0;
        m_conf      = 0;
        e_rdata     = 8'h00;
        e_upd       = 1'b0;
        e_upd_addr  = 8'h00;
        e_upd_src   = 1'b0;
        e_rsp       = 1'b0;
        e_rsp_rdata = 8'h00;
        e_rsp_err   = 1'b0;
    endtask

    task automatic drive_idle();
        bus.i2c_active     = 1'b0;
        bus.i2c_addr       = 8'h00;
        bus.i2c_wdata      = 8'h00;
        bus.i2c_wr_pulse   = 1'b0;
        bus.host_req_valid = 1'b0;
        bus.host_req_we    = 1'b0;
        bus.host_req_addr  = 8'h00;
        bus.host_req_wdata = 8'h00;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        drive_idle();
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_ready", bus.host_req_ready, 1'b0);
        check_eq("rst_rdata", bus.i2c_rdata, 8'h00);
        check_eq("rst_upd", bus.reg_upd_pulse, 1'b0);
        check_eq("rst_rsp", bus.host_rsp_valid, 1'b0);
        check_eq("rst_conf", conflict_cnt, 16'h0000);
        check_eq("rst_lockto", lock_timeout, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        model_clear();
    endtask

    // One clock of traffic: drive, compare against the model, then advance the model
    task automatic run_cycle(input logic wr, input logic [7:0] ia, input logic [7:0] iwd,
                             input logic hv, input logic hwe, input logic [7:0] ha,
                             input logic [7:0] hwd);
        logic exp_ready;
        @(negedge clk);
        bus.i2c_wr_pulse   = wr;
        bus.i2c_addr       = ia;
        bus.i2c_wdata      = iwd;
        bus.host_req_valid = hv;
        bus.host_req_we    = hwe;
        bus.host_req_addr  = ha;
        bus.host_req_wdata = hwd;
        #1;
        exp_ready = (busy == 0) && !wr;
        check_eq("i2c_rdata", bus.i2c_rdata, e_rdata);
        check_eq("upd_pulse", bus.reg_upd_pulse, e_upd);
        check_eq("upd_addr", bus.reg_upd_addr, e_upd_addr);
        check_eq("upd_src", bus.reg_upd_src, e_upd_src);
        check_eq("rsp_valid", bus.host_rsp_valid, e_rsp);
        check_eq("rsp_rdata", bus.host_rsp_rdata, e_rsp_rdata);
        check_eq("rsp_err", bus.host_rsp_err, e_rsp_err);
        check_eq("req_ready", bus.host_req_ready, exp_ready);
        check_eq("conflict_cnt", conflict_cnt, m_conf);
        check_eq("lock_timeout", lock_timeout, 1'b0);

        e_rdata     = in_range(ia) ? m_regs[ia] : 8'hFF;
        e_upd       = 1'b0;
        e_upd_addr  = 8'h00;
        e_upd_src   = 1'b0;
        e_rsp       = 1'b0;
        e_rsp_rdata = 8'h00;
        e_rsp_err   = 1'b0;
        if (wr && in_range(ia)) begin
            m_regs[ia] = iwd;
            e_upd      = 1'b1;
            e_upd_addr = ia;
        end
        if (busy == 1) begin
            if (wr) begin
                if (m_conf < 65535) m_conf++;
            end else begin
                if (p_we && in_range(p_addr)) begin
                    m_regs[p_addr] = p_wdata;
                    e_upd      = 1'b1;
                    e_upd_addr = p_addr;
                    e_upd_src  = 1'b1;
                end
                e_rsp       = 1'b1;
                e_rsp_err   = !in_range(p_addr);
                e_rsp_rdata = (!p_we && in_range(p_addr)) ? m_regs[p_addr] : 8'h00;
                busy        = 2;
            end
        end else if (busy == 2) begin
            busy = 0;
        end else if (hv && exp_ready) begin
            p_we    = hwe;
            p_addr  = ha;
            p_wdata = hwd;
            busy    = 1;
        end
    endtask

    task automatic idle_cycle(input logic [7:0] ia);
        run_cycle(1'b0, ia, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    int first_acc;

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b1;
        drive_idle();
        model_clear();
        apply_reset();

        // Host write 0x10 <= A5, then read it back; I2C read of 0x10 sees A5
        run_cycle(1'b0, 8'h10, 8'h00, 1'b1, 1'b1, 8'h10, 8'hA5);
        idle_cycle(8'h10);
        idle_cycle(8'h10);
        check_eq("t1_wr_upd", bus.reg_upd_pulse, 1'b1);
        check_eq("t1_wr_src", bus.reg_upd_src, 1'b1);
        run_cycle(1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00);
        idle_cycle(8'h10);
        idle_cycle(8'h10);
        check_eq("t1_rd_data", bus.host_rsp_rdata, 8'hA5);
        check_eq("t1_i2c_rd", bus.i2c_rdata, 8'hA5);

        // I2C write during EXEC of a host write: host commit slips one cycle
        run_cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h04, 8'h11);
        run_cycle(1'b1, 8'h03, 8'h5A, 1'b0, 1'b0, 8'h00, 8'h00);
        idle_cycle(8'h03);
        check_eq("t2_upd0_src", bus.reg_upd_src, 1'b0);
        idle_cycle(8'h04);
        check_eq("t2_upd1_src", bus.reg_upd_src, 1'b1);
        check_eq("t2_conflict", conflict_cnt, 16'd1);
        idle_cycle(8'h04);
        check_eq("t2_reg4", bus.i2c_rdata, 8'h11);

        // Same-address stall: a stalled host read returns the new I2C value
        run_cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h07, 8'h00);
        run_cycle(1'b1, 8'h07, 8'hC3, 1'b0, 1'b0, 8'h00, 8'h00);
        idle_cycle(8'h00);
        idle_cycle(8'h00);
        check_eq("t2b_rd_new", bus.host_rsp_rdata, 8'hC3);

        // Out of range (NUM_REGS = 32): host write error, I2C read FF, I2C write dropped
        run_cycle(1'b0, 8'h20, 8'h00, 1'b1, 1'b1, 8'h20, 8'h99);
        idle_cycle(8'h20);
        idle_cycle(8'h20);
        check_eq("t3_err", bus.host_rsp_err, 1'b1);
        check_eq("t3_no_upd", bus.reg_upd_pulse, 1'b0);
        check_eq("t3_i2c_ff", bus.i2c_rdata, 8'hFF);
        run_cycle(1'b1, 8'h20, 8'h77, 1'b0, 1'b0, 8'h00, 8'h00);
        idle_cycle(8'h00);
        check_eq("t3_i2c_no_upd", bus.reg_upd_pulse, 1'b0);

        // Reset while a host write sits in EXEC: it must not commit
        run_cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h08, 8'h77);
        apply_reset();
        idle_cycle(8'h08);
        check_eq("t4_ready", bus.host_req_ready, 1'b1);
        idle_cycle(8'h08);
        check_eq("t4_not_committed", bus.i2c_rdata, 8'h00);

        // Random traffic
        for (int n = 0; n < 800; n++) begin
            run_cycle($urandom_range(0, 3) == 0, 8'($urandom_range(0, 47)), 8'($urandom),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      8'($urandom_range(0, 47)), 8'($urandom));
        end
        for (int n = 0; n < 3; n++) idle_cycle(8'h00);

        // Conflict counter saturation
        apply_reset();
        run_cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h05, 8'h3C);
        for (int n = 0; n < 65540; n++) begin
            run_cycle(1'b1, 8'h06, 8'($urandom), 1'b0, 1'b0, 8'h00, 8'h00);
        end
        idle_cycle(8'h05);
        idle_cycle(8'h05);
        idle_cycle(8'h05);
        check_eq("t6_sat", conflict_cnt, 16'hFFFF);
        check_eq("t6_reg5", bus.i2c_rdata, 8'h3C);

        // I2C lock: active for 150 cycles with the host requesting throughout
        apply_reset();
        first_acc = -1;
        for (int k = 0; k < 150; k++) begin
            @(negedge clk);
            bus.i2c_active     = 1'b1;
            bus.host_req_valid = 1'b1;
            bus.host_req_we    = 1'b0;
            bus.host_req_addr  = 8'h00;
            #1;
            if (k == 50) check_eq("t5_lockto_early", lock_timeout, 1'b0);
            if (first_acc < 0 && bus.host_req_ready) first_acc = k;
        end
        @(negedge clk);
        drive_idle();
        for (int k = 0; k < 4; k++) @(negedge clk);
        #1;
        check_eq("t5_first_accept", first_acc, EXP_FIRST_ACC);
        check_eq("t5_lockto_sticky", lock_timeout, EXP_LOCK_TO);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
